// File: rtl/strobe_arbiter.sv
// Round-robin arbiter sharing one toggle-flag strobe crossing between NUM_REQ requesters.
// Strobes are spaced by an optional return ack (with timeout) plus a fixed holdoff.
module strobe_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned GAP     = 4,
    parameter int unsigned USE_ACK = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     strobe_out,
    output logic [ID_W+WIDTH-1:0]    data_out,
    input  logic                     ack_in,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [ID_W-1:0]          last_grant
);

    localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StHoldoff} state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [ID_W+WIDTH-1:0] data_q, data_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    logic [ID_W-1:0]       grant, grant_next, idx;
    logic                  any_valid;
    logic [WIDTH-1:0]      payload [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : gen_payload
        assign payload[i] = req_data[i*WIDTH +: WIDTH];
    end

    // First valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin : arbitrate
        grant      = '0;
        grant_next = '0;
        any_valid  = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(rr_q) + i) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                grant      = idx;
                grant_next = ID_W'((32'(rr_q) + i + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!reset_n) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            last_grant_q <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        rr_d         = rr_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d      = StIssue;
                    rr_d         = grant_next;
                    last_grant_d = grant;
                    data_d       = {grant, payload[grant]};
                end
            end
            StIssue: begin
                state_d = (USE_ACK != 0) ? StWaitAck : StHoldoff;
                cnt_d   = '0;
            end
            StWaitAck: begin
                // An ack on the final wait cycle still counts as a clean ack.
                if (ack_in) begin
                    state_d = StHoldoff;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d   = StHoldoff;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q == CntW'(GAP - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : outputs
        req_ready = '0;
        if (reset_n && state_q == StIdle && any_valid) begin
            req_ready[grant] = 1'b1;
        end
        strobe_out = (state_q == StIssue);
        busy       = (state_q != StIdle);
    end

    assign data_out    = data_q;
    assign timeout_err = timeout_q;
    assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_strobe_arbiter.sv
// Bench for strobe_arbiter: transaction-timing reference model checked every cycle,
// directed scenarios pinned by literal cycle numbers, then randomized traffic.
module tb_strobe_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 16;
    localparam int INF     = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic                     ack_in = 1'b0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     strobe_out, busy, timeout_err;
    logic [ID_W+WIDTH-1:0]    data_out;
    logic [ID_W-1:0]          last_grant;

    strobe_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .GAP(GAP),
                     .USE_ACK(1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .strobe_out(strobe_out), .data_out(data_out),
        .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err), .last_grant(last_grant)
    );

    // Holdoff-only instance
    logic                     reset_b = 1'b0;
    logic [NUM_REQ-1:0]       valid_b = '0;
    logic [NUM_REQ*WIDTH-1:0] data_b = '0;
    logic [NUM_REQ-1:0]       ready_b;
    logic                     strobe_b, busy_b, to_b;
    logic [ID_W+WIDTH-1:0]    dout_b;
    logic [ID_W-1:0]          last_b;

    strobe_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .GAP(GAP),
                     .USE_ACK(0), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .reset_n(reset_b), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .strobe_out(strobe_b), .data_out(dout_b),
        .ack_in(1'b0), .busy(busy_b), .timeout_err(to_b), .last_grant(last_b)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ack driver: 0 off, 1 fixed delay after each strobe, 2 random, 3 at one chosen cycle
    int ack_mode = 0;
    int ack_k = 3;
    int ack_at = -1;
    int last_strobe = -100;

    initial forever begin
        @(posedge clk);
        #1;
        ack_in = (ack_mode == 1 && cyc == last_strobe + ack_k) ||
                 (ack_mode == 2 && $urandom_range(5) == 0) ||
                 (ack_mode == 3 && cyc == ack_at);
    end

    // Reference model: per-transaction timeline relative to the transfer cycle m_t
    int m_known = 0, m_active = 0, m_t = 0, m_idle_at = 0, m_to = -1, m_acked = 0, m_rr = 0;
    int m_last = 0;
    logic [ID_W+WIDTH-1:0] m_data = '0;
    int slog[$], glog[$], tlog[$];

    initial forever begin
        int g, ix;
        logic m_idle, exp_strobe;
        logic [NUM_REQ-1:0] exp_ready;
        @(negedge clk);
        if (reset_n === 1'b1 && strobe_out === 1'b1) begin
            slog.push_back(cyc);
            glog.push_back(int'(last_grant));
            last_strobe = cyc;
        end
        if (reset_n === 1'b1 && timeout_err === 1'b1) tlog.push_back(cyc);
        if (!reset_n) begin
            check("ready_in_reset", 32'(req_ready), 32'd0);
            m_known = 1; m_active = 0; m_rr = 0; m_last = 0; m_data = '0; m_to = -1;
        end else if (m_known != 0) begin
            m_idle = (m_active == 0) || (cyc >= m_idle_at);
            g = -1;
            exp_ready = '0;
            if (m_idle) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    ix = (m_rr + i) % NUM_REQ;
                    if (g < 0 && req_valid[ix]) g = ix;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_strobe = (m_active != 0) && (cyc == m_t + 1);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("strobe_out", 32'(strobe_out), 32'(exp_strobe));
            check("busy", 32'(busy), 32'(!m_idle));
            check("timeout_err", 32'(timeout_err), 32'((m_active != 0) && cyc == m_to));
            check("data_out", 32'(data_out), 32'(m_data));
            check("last_grant", 32'(last_grant), 32'(m_last));
            if (m_active != 0 && m_acked == 0 && cyc >= m_t + 2 && cyc <= m_t + 1 + TIMEOUT) begin
                if (ack_in) begin
                    m_acked = 1;
                    m_idle_at = cyc + GAP + 1;
                end else if (cyc == m_t + 1 + TIMEOUT) begin
                    m_acked = 1;
                    m_to = cyc + 1;
                    m_idle_at = cyc + GAP + 1;
                end
            end
            if (g >= 0) begin
                m_active = 1; m_t = cyc; m_acked = 0; m_to = -1; m_idle_at = INF;
                m_data = {2'(g), req_data[g*WIDTH +: WIDTH]};
                m_last = g;
                m_rr = (g + 1) % NUM_REQ;
            end
        end
    end

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        req_valid = '0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    // Holdoff-only instance: requester 1 always valid, payload increments per accept
    int b_done = 0;
    int sb_cyc[$];
    logic [ID_W+WIDTH-1:0] sb_dat[$];
    logic [ID_W+WIDTH-1:0] hist_b [128];

    initial begin
        logic acc;
        repeat (3) step();
        reset_b = 1'b1;
        valid_b = 4'b0010;
        data_b[15:8] = 8'h01;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            acc = ready_b[1];
            if (cyc < 128) hist_b[cyc] = dout_b;
            if (strobe_b === 1'b1) begin
                sb_cyc.push_back(cyc);
                sb_dat.push_back(dout_b);
            end
            step();
            if (acc) data_b[15:8] = data_b[15:8] + 8'h01;
        end
        check("b_strobe_count_min3", 32'(sb_cyc.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < sb_cyc.size(); i++) begin
            check("b_data", 32'(sb_dat[i]), 32'h100 + 32'(i + 1));
            if (sb_cyc[i] + 5 < 128) check("b_data_stable", 32'(hist_b[sb_cyc[i] + 5]), 32'(sb_dat[i]));
            if (i > 0) check("b_spacing", 32'(sb_cyc[i] - sb_cyc[i-1]), 32'd6);
        end
        b_done = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) step();
        reset_n = 1'b1;

        // Single request, id 2 payload A5
        ack_mode = 1; ack_k = 3;
        step();
        base = cyc;
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        @(negedge clk);
        check("s1_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("s1_strobe", 32'(strobe_out), 32'd1);
        check("s1_data", 32'(data_out), 32'h2A5);
        check("s1_last", 32'(last_grant), 32'd2);
        check("s1_busy", 32'(busy), 32'd1);
        repeat (20) step();

        // All valid, ack 3 cycles after each strobe: spacing 9, grants in rotation
        do_reset();
        slog.delete(); glog.delete(); tlog.delete();
        base = cyc;
        req_valid = 4'b1111;
        req_data = 32'h44332211;
        wait_neg(base + 40);
        step();
        req_valid = '0;
        check("s2_strobe_count", 32'(slog.size()), 32'd5);
        for (int i = 0; i < 5 && i < slog.size(); i++) begin
            check("s2_strobe_cycle", 32'(slog[i] - base), 32'(1 + 9 * i));
            check("s2_grant", 32'(glog[i]), 32'(i % 4));
        end
        check("s2_no_timeout", 32'(tlog.size()), 32'd0);
        repeat (10) step();

        // No ack: timeout pulse at +18, late ack at +19 ignored, idle at +22
        do_reset();
        tlog.delete();
        ack_mode = 3;
        step();
        base = cyc;
        ack_at = base + 19;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        wait_neg(base + 21);
        check("s3_busy_last_holdoff", 32'(busy), 32'd1);
        wait_neg(base + 22);
        check("s3_idle", 32'(busy), 32'd0);
        check("s3_timeout_count", 32'(tlog.size()), 32'd1);
        if (tlog.size() > 0) check("s3_timeout_cycle", 32'(tlog[0] - base), 32'd18);
        step();

        // Stray ack in IDLE, then ack exactly on the last wait cycle
        do_reset();
        slog.delete(); tlog.delete();
        ack_at = cyc + 2;
        repeat (3) step();
        base = cyc;
        ack_at = base + 17;
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        step();
        req_valid = '0;
        wait_neg(base + 1);
        check("s4_strobe", 32'(strobe_out), 32'd1);
        check("s4_data", 32'(data_out), 32'h2A5);
        check("s4_last", 32'(last_grant), 32'd2);
        wait_neg(base + 24);
        check("s4_no_timeout", 32'(tlog.size()), 32'd0);
        check("s4_idle", 32'(busy), 32'd0);
        check("s4_one_strobe", 32'(slog.size()), 32'd1);
        step();

        // Reset during WAIT_ACK, then 1001 grants 0 then 3
        do_reset();
        ack_mode = 0;
        base = cyc;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        while (cyc < base + 5) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("s5_strobe", 32'(strobe_out), 32'd0);
        check("s5_data", 32'(data_out), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_last", 32'(last_grant), 32'd0);
        check("s5_timeout", 32'(timeout_err), 32'd0);
        step();
        glog.delete();
        ack_mode = 1;
        req_valid = 4'b1001;
        repeat (24) step();
        req_valid = '0;
        check("s5_grant_count_min2", 32'(glog.size() >= 2), 32'd1);
        if (glog.size() >= 2) begin
            check("s5_grant0", 32'(glog[0]), 32'd0);
            check("s5_grant1", 32'(glog[1]), 32'd3);
        end
        repeat (30) step();

        // Randomized traffic with random acks and rare resets
        do_reset();
        ack_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            req_valid = NUM_REQ'($urandom);
            req_data = $urandom;
            reset_n = ($urandom_range(499) != 0);
            step();
        end
        reset_n = 1'b1;
        req_valid = '0;
        repeat (40) step();

        wait (b_done != 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
